// File: rtl/note_envelope.sv
// ADSR amplitude shaper: steps an 8-bit gain on the 1/48 s beat and scales the note player's samples by it.
// Define NOTE_ENVELOPE_EXP_RELEASE_EN for an exponential (7/8 per beat) release instead of the linear one.
module note_envelope #(
  parameter logic [7:0] ATTACK_STEP   = 8'd64,
  parameter logic [7:0] DECAY_STEP    = 8'd16,
  parameter logic [7:0] SUSTAIN_LEVEL = 8'd192,
  parameter logic [7:0] RELEASE_STEP  = 8'd32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        play_enable,
  input  logic        note_start,
  input  logic        note_done,
  input  logic        beat,
  input  logic [15:0] sample_in,
  input  logic        sample_ready_in,
  output logic [15:0] sample_out,
  output logic        sample_ready_out,
  output logic [7:0]  gain,
  output logic        env_idle
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } env_state_t;

  env_state_t state, state_n;
  logic [7:0] gain_n;
  logic       step;
  logic [8:0] attack_sum;
  logic [8:0] decay_floor;
`ifdef NOTE_ENVELOPE_EXP_RELEASE_EN
  logic [7:0] release_dec;
`endif

  assign step        = beat & play_enable & ~note_start;
  assign attack_sum  = {1'b0, gain} + {1'b0, ATTACK_STEP};
  assign decay_floor = {1'b0, SUSTAIN_LEVEL} + {1'b0, DECAY_STEP};
`ifdef NOTE_ENVELOPE_EXP_RELEASE_EN
  assign release_dec = ((gain >> 3) == 8'd0) ? 8'd1 : (gain >> 3);
`endif

  always_comb begin
    state_n = state;
    gain_n  = gain;
    if (note_start) begin
      // Retrigger keeps the current gain so the attack ramps from wherever we are.
      state_n = ATTACK;
    end else begin
      if (step) begin
        case (state)
          ATTACK: begin
            if (attack_sum >= 9'd255) begin
              gain_n  = 8'd255;
              state_n = DECAY;
            end else begin
              gain_n = attack_sum[7:0];
            end
          end
          DECAY: begin
            if ({1'b0, gain} <= decay_floor) begin
              gain_n  = SUSTAIN_LEVEL;
              state_n = SUSTAIN;
            end else begin
              gain_n = gain - DECAY_STEP;
            end
          end
          RELEASE: begin
`ifdef NOTE_ENVELOPE_EXP_RELEASE_EN
            if (gain <= release_dec) begin
              gain_n  = 8'd0;
              state_n = IDLE;
            end else begin
              gain_n = gain - release_dec;
            end
`else
            if (gain <= RELEASE_STEP) begin
              gain_n  = 8'd0;
              state_n = IDLE;
            end else begin
              gain_n = gain - RELEASE_STEP;
            end
`endif
          end
          default: ;
        endcase
      end
      if (state == IDLE) begin
        gain_n = 8'd0;
      end
      // Release needs no beat; any gain step taken this cycle still lands.
      if (note_done && (state == ATTACK || state == DECAY || state == SUSTAIN)) begin
        state_n = RELEASE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      gain     <= 8'd0;
      env_idle <= 1'b1;
    end else begin
      state    <= state_n;
      gain     <= gain_n;
      env_idle <= (state_n == IDLE);
    end
  end

  // Sample handshake: sample_ready_in qualifies sample_in for one cycle; sample_ready_out
  // pulses exactly one cycle later with the scaled value, which then holds until the next pulse.
  logic signed [24:0] sample_ext;
  logic signed [24:0] gain_ext;
  logic signed [24:0] product;
  logic signed [24:0] scaled;

  assign sample_ext = {{9{sample_in[15]}}, sample_in};
  assign gain_ext   = {17'd0, gain};
  assign product    = sample_ext * gain_ext;
  assign scaled     = product >>> 8;

  always_ff @(posedge clk) begin
    if (reset) begin
      sample_out       <= 16'd0;
      sample_ready_out <= 1'b0;
    end else begin
      sample_ready_out <= sample_ready_in;
      if (sample_ready_in) begin
        sample_out <= scaled[15:0];
      end
    end
  end

endmodule

// File: tb/tb_note_envelope.sv
// Directed bench for note_envelope: envelope shape, release, retrigger, freeze and sample scaling.
// Expected values are hand-computed from the default step/level parameters.
module tb_note_envelope;

  logic        clk = 1'b0;
  logic        reset;
  logic        play_enable;
  logic        note_start;
  logic        note_done;
  logic        beat;
  logic [15:0] sample_in;
  logic        sample_ready_in;
  logic [15:0] sample_out;
  logic        sample_ready_out;
  logic [7:0]  gain;
  logic        env_idle;

  int pass_cnt = 0;
  int total_cnt = 0;

  note_envelope dut (
    .clk              (clk),
    .reset            (reset),
    .play_enable      (play_enable),
    .note_start       (note_start),
    .note_done        (note_done),
    .beat             (beat),
    .sample_in        (sample_in),
    .sample_ready_in  (sample_ready_in),
    .sample_out       (sample_out),
    .sample_ready_out (sample_ready_out),
    .gain             (gain),
    .env_idle         (env_idle)
  );

  always #5 clk = ~clk;

  // Inputs change 1 ns after a rising edge; outputs are read at the same point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_beat();
    beat = 1'b1;
    tick();
    beat = 1'b0;
  endtask

  task automatic start_note();
    note_start = 1'b1;
    tick();
    note_start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    total_cnt++;
    if (gain !== 8'd0) $display("FAIL reset_gain got %0d want 0", gain);
    else pass_cnt++;
    total_cnt++;
    if (env_idle !== 1'b1) $display("FAIL reset_idle got %b want 1", env_idle);
    else pass_cnt++;
    total_cnt++;
    if (sample_out !== 16'd0 || sample_ready_out !== 1'b0)
      $display("FAIL reset_sample got %h/%b want 0000/0", sample_out, sample_ready_out);
    else pass_cnt++;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_attack_decay();
    logic [7:0] exp_g [10] = '{8'd64, 8'd128, 8'd192, 8'd255, 8'd239,
                              8'd223, 8'd207, 8'd192, 8'd192, 8'd192};
    start_note();
    total_cnt++;
    if (env_idle !== 1'b0 || gain !== 8'd0)
      $display("FAIL ad_start got idle=%b gain=%0d want idle=0 gain=0", env_idle, gain);
    else pass_cnt++;
    for (int i = 0; i < 10; i++) begin
      do_beat();
      total_cnt++;
      if (gain !== exp_g[i]) $display("FAIL ad_beat%0d got %0d want %0d", i, gain, exp_g[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid_sustain();
    reset = 1'b1;
    sample_in = 16'h4000;
    sample_ready_in = 1'b1;
    tick();
    reset = 1'b0;
    total_cnt++;
    if (gain !== 8'd0 || env_idle !== 1'b1 || sample_out !== 16'd0 || sample_ready_out !== 1'b0)
      $display("FAIL rst_mid got gain=%0d idle=%b out=%h rdy=%b want 0/1/0000/0",
               gain, env_idle, sample_out, sample_ready_out);
    else pass_cnt++;
    tick();
    sample_ready_in = 1'b0;
    total_cnt++;
    if (sample_ready_out !== 1'b1 || sample_out !== 16'd0)
      $display("FAIL rst_gain0_sample got out=%h rdy=%b want 0000/1", sample_out, sample_ready_out);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_release();
    logic [7:0] g;
    logic [7:0] dec;
    logic [7:0] g_exp;
    start_note();
    for (int i = 0; i < 8; i++) do_beat();
    note_done = 1'b1;
    tick();
    total_cnt++;
    if (gain !== 8'd192 || env_idle !== 1'b0)
      $display("FAIL rel_enter got gain=%0d idle=%b want 192/0", gain, env_idle);
    else pass_cnt++;
    g = 8'd192;
    for (int i = 0; i < 64 && g != 8'd0; i++) begin
`ifdef NOTE_ENVELOPE_EXP_RELEASE_EN
      dec = ((g >> 3) == 8'd0) ? 8'd1 : (g >> 3);
`else
      dec = 8'd32;
`endif
      g_exp = (g <= dec) ? 8'd0 : g - dec;
      do_beat();
      total_cnt++;
      if (gain !== g_exp) $display("FAIL rel_beat%0d got %0d want %0d", i, gain, g_exp);
      else pass_cnt++;
      total_cnt++;
      if (env_idle !== (g_exp == 8'd0)) $display("FAIL rel_idle%0d got %b want %b", i, env_idle, g_exp == 8'd0);
      else pass_cnt++;
      g = gain;
    end
    note_done = 1'b0;
    do_beat();
    total_cnt++;
    if (gain !== 8'd0 || env_idle !== 1'b1)
      $display("FAIL idle_hold got gain=%0d idle=%b want 0/1", gain, env_idle);
    else pass_cnt++;
  endtask

  task automatic test_scaling();
    start_note();
    do_beat();
    do_beat();
    sample_in = 16'h4000;
    sample_ready_in = 1'b1;
    total_cnt++;
    if (sample_ready_out !== 1'b0) $display("FAIL scale_early got rdy=%b want 0", sample_ready_out);
    else pass_cnt++;
    tick();
    sample_ready_in = 1'b0;
    total_cnt++;
    if (sample_ready_out !== 1'b1 || sample_out !== 16'h2000)
      $display("FAIL scale_128 got out=%h rdy=%b want 2000/1", sample_out, sample_ready_out);
    else pass_cnt++;
    sample_in = 16'h1234;
    tick();
    total_cnt++;
    if (sample_ready_out !== 1'b0 || sample_out !== 16'h2000)
      $display("FAIL scale_hold got out=%h rdy=%b want 2000/0", sample_out, sample_ready_out);
    else pass_cnt++;
    do_beat();
    do_beat();
    sample_in = 16'hC000;
    sample_ready_in = 1'b1;
    tick();
    sample_ready_in = 1'b0;
    total_cnt++;
    if (gain !== 8'd255 || sample_ready_out !== 1'b1 || sample_out !== 16'hC040)
      $display("FAIL scale_255 got gain=%0d out=%h rdy=%b want 255/c040/1", gain, sample_out, sample_ready_out);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_back_to_back();
    sample_in = 16'h0100;
    sample_ready_in = 1'b1;
    tick();
    sample_in = 16'hFF00;
    total_cnt++;
    if (sample_ready_out !== 1'b1 || sample_out !== 16'h00FF)
      $display("FAIL b2b_first got out=%h rdy=%b want 00ff/1", sample_out, sample_ready_out);
    else pass_cnt++;
    tick();
    sample_ready_in = 1'b0;
    total_cnt++;
    if (sample_ready_out !== 1'b1 || sample_out !== 16'hFF01)
      $display("FAIL b2b_second got out=%h rdy=%b want ff01/1", sample_out, sample_ready_out);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (sample_ready_out !== 1'b0) $display("FAIL b2b_end got rdy=%b want 0", sample_ready_out);
    else pass_cnt++;
  endtask

  task automatic test_simultaneous();
    logic [7:0] g96;
    logic [7:0] after_freeze;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    start_note();
    do_beat();
    do_beat();
    do_beat();
    note_done = 1'b1;
    tick();
    note_done = 1'b0;
    do_beat();
    do_beat();
    do_beat();
`ifdef NOTE_ENVELOPE_EXP_RELEASE_EN
    g96 = 8'd129;
    after_freeze = 8'd193 - 8'd24;
`else
    g96 = 8'd96;
    after_freeze = 8'd128;
`endif
    total_cnt++;
    if (gain !== g96) $display("FAIL sim_pre got %0d want %0d", gain, g96);
    else pass_cnt++;
    note_start = 1'b1;
    note_done = 1'b1;
    beat = 1'b1;
    tick();
    note_start = 1'b0;
    note_done = 1'b0;
    beat = 1'b0;
    total_cnt++;
    if (gain !== g96 || env_idle !== 1'b0)
      $display("FAIL sim_retrig got gain=%0d idle=%b want %0d/0", gain, env_idle, g96);
    else pass_cnt++;
    do_beat();
    total_cnt++;
    if (gain !== g96 + 8'd64) $display("FAIL sim_attack got %0d want %0d", gain, g96 + 8'd64);
    else pass_cnt++;
    play_enable = 1'b0;
    do_beat();
    do_beat();
    total_cnt++;
    if (gain !== g96 + 8'd64) $display("FAIL freeze got %0d want %0d", gain, g96 + 8'd64);
    else pass_cnt++;
    note_done = 1'b1;
    tick();
    note_done = 1'b0;
    play_enable = 1'b1;
    do_beat();
    total_cnt++;
    if (gain !== after_freeze) $display("FAIL freeze_release got %0d want %0d", gain, after_freeze);
    else pass_cnt++;
  endtask

  initial begin
    reset = 1'b1;
    play_enable = 1'b1;
    note_start = 1'b0;
    note_done = 1'b0;
    beat = 1'b0;
    sample_in = 16'd0;
    sample_ready_in = 1'b0;
    test_reset();
    test_attack_decay();
    test_reset_mid_sustain();
    test_release();
    test_scaling();
    test_back_to_back();
    test_simultaneous();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/note_envelope.md
Name: note_envelope

Overview:
- ADSR amplitude shaper that sits directly downstream of the note player.
- Consumes the note player's 16-bit signed sample stream and its note start/done events.
- Produces an envelope-scaled sample stream for the codec/mixer.
- Envelope advances on the 1/48 s beat; each sample is scaled by an 8-bit gain.

Parameters:
- ATTACK_STEP, 8'd64: gain increment per beat in ATTACK.
- DECAY_STEP, 8'd16: gain decrement per beat in DECAY.
- SUSTAIN_LEVEL, 8'd192: gain held in SUSTAIN.
- RELEASE_STEP, 8'd32: gain decrement per beat in RELEASE (linear mode).

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- play_enable  input  1  high = envelope runs; low = gain frozen (beats ignored)
- note_start  input  1  one-cycle pulse: new note loaded (note player load_new_note)
- note_done  input  1  level: current note's duration expired (note player done_with_note)
- beat  input  1  one-cycle 1/48 s tick
- sample_in  input  16  signed sample from note player
- sample_ready_in  input  1  one-cycle pulse: sample_in valid
- sample_out  output  16  signed scaled sample
- sample_ready_out  output  1  one-cycle pulse: sample_out updated
- gain  output  8  current envelope gain (debug/mixer use)
- env_idle  output  1  high when state == IDLE

Behaviour:
- Reset (synchronous, active-high, dominates all inputs): state IDLE; gain 0; sample_out 0; sample_ready_out 0; env_idle 1.
- States: IDLE, ATTACK, DECAY, SUSTAIN, RELEASE. State and gain are registered.
- note_start, in any state: next state ATTACK; gain keeps its current value (retrigger without a click).
  - No gain step occurs on that cycle, even if beat is also high.
  - note_start beats note_done in the same cycle.
- Gain stepping happens only on cycles with beat=1, play_enable=1 and note_start=0:
  - ATTACK: gain = min(gain+ATTACK_STEP, 255), computed at 9 bits. Reaching 255 -> DECAY.
  - DECAY: if gain-DECAY_STEP <= SUSTAIN_LEVEL, gain = SUSTAIN_LEVEL and go to SUSTAIN; else gain -= DECAY_STEP.
  - SUSTAIN: gain unchanged.
  - RELEASE: gain = max(gain-RELEASE_STEP, 0). Reaching 0 -> IDLE.
- Release trigger: note_done=1 while in ATTACK, DECAY or SUSTAIN moves to RELEASE on the next clock, with no beat needed.
  - The gain step on that cycle still applies per the current state.
- IDLE: gain held at 0. Ignores note_done and beat.
- play_enable=0: state and gain frozen, but note_start and note_done transitions still apply. Sample path keeps running.
- Sample path:
  - On sample_ready_in=1, register sample_out = low 16 bits of (signed(sample_in) * signed({1'b0,gain})) >>> 8.
  - The product is 25 bits with an arithmetic shift; no overflow is possible.
  - The gain used is the registered value in the same cycle.
  - sample_ready_out pulses exactly 1 cycle after sample_ready_in. Latency is 1 clock.
  - sample_out holds between pulses.
  - Back-to-back sample_ready_in on consecutive cycles yields back-to-back outputs.
- A sample_ready_in arriving with gain 0 still produces sample_ready_out, with sample_out=0.
- gain output and env_idle are taken directly from the registers.

Optional Feature:
- Macro: NOTE_ENVELOPE_EXP_RELEASE_EN.
- Defined: RELEASE ignores RELEASE_STEP.
  - Each qualifying beat: gain = gain - max(gain>>3, 1), floored at 0.
  - This gives an exponential 7/8 decay. Reaching 0 -> IDLE.
- Undefined: linear RELEASE as above. No extra logic is synthesized.

Test Plan:
- Reset mid-SUSTAIN (gain 192), then sample_ready_in pulse -> next cycle gain=0, state IDLE, sample_out=0, env_idle=1.
- Attack/decay with defaults: note_start, then beats -> gain 64,128,192,255 (DECAY), 239,223,207,192 (SUSTAIN); further beats hold 192.
- Linear release: note_done=1 in SUSTAIN (192) -> RELEASE; beats -> 160,128,96,64,32,0; env_idle=1 after the final beat.
- Scaling: gain 128, sample_in 16'h4000 -> sample_out 16'h2000. Gain 255, sample_in 16'hC000 -> 16'hC040. Both with sample_ready_out exactly one cycle after input.
- Simultaneous events: in RELEASE at gain 96, note_start + note_done + beat in the same cycle -> ATTACK, gain stays 96. Next beat -> 160. play_enable=0 with beats -> gain unchanged.
- With NOTE_ENVELOPE_EXP_RELEASE_EN: release from 192 -> 168,147,129,... reaches 0 via minimum step 1 (…,2,1,0) -> IDLE.
